// File: rtl/uart_buffered_pkg.sv
// uart_buffered_pkg: shared enums, oversample constant and parity helper for the buffered UART.
package uart_buffered_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // Data is zero-extended to 9 bits, so padding never changes the result.
    function automatic logic parity_bit(logic [8:0] d, parity_e p);
        return (p == PAR_ODD) ^ (^d);
    endfunction

endpackage

// File: rtl/uart_buffered_fifo.sv
// fifo_sync: single-clock first-word fall-through FIFO with occupancy count.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the push lands in, so a full FIFO still accepts push+pop.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/uart_buffered.sv
// uart_buffered: UART with TX/RX FIFOs, configurable width/parity/stop bits and sticky errors.
module uart_buffered import uart_buffered_pkg::*; #(
    parameter int      CLK_HZ     = 50_000_000,
    parameter int      BAUD       = 115_200,
    parameter int      DATA_W     = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_i,
    output logic                          tx_o,
    input  logic [DATA_W-1:0]             din_i,
    input  logic                          we_i,
    output logic                          txavail_o,
    output logic [DATA_W-1:0]             dout_o,
    input  logic                          re_i,
    output logic                          rxavail_o,
    output logic [$clog2(FIFO_DEPTH):0]   txcount_o,
    output logic [$clog2(FIFO_DEPTH):0]   rxcount_o,
    output logic [2:0]                    err_o,
    input  logic                          clr_err_i
);
    localparam int DIV_RAW = (CLK_HZ + BAUD * UART_OVERSAMPLE / 2) / (BAUD * UART_OVERSAMPLE);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV + 1);

    logic [DW-1:0]     div_q;
    logic              tick;
    logic              tx_pop, tx_full, tx_empty, tx_end, tx_load;
    logic [DATA_W-1:0] tx_head;
    tx_state_e         tx_st_q, tx_st_d;
    logic [3:0]        tx_ph_q, tx_ph_d, tx_bit_q, tx_bit_d;
    logic              tx_stop_q, tx_stop_d, tx_par_q, tx_par_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              rx_s1_q, rx_s2_q, rx_push, rx_full, rx_empty, samp, set_par, set_frm;
    rx_state_e         rx_st_q, rx_st_d;
    logic [3:0]        rx_ph_q, rx_ph_d, rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [2:0]        err_q, err_d;

    assign tick = div_q == DW'(DIV - 1);

    fifo_sync #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(we_i && txavail_o), .pop_i(tx_pop),
        .din_i(din_i), .dout_o(tx_head), .count_o(txcount_o), .full_o(tx_full), .empty_o(tx_empty)
    );

    fifo_sync #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(rx_push), .pop_i(re_i),
        .din_i(rx_sh_q), .dout_o(dout_o), .count_o(rxcount_o), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign txavail_o = !tx_full;
    assign rxavail_o = !rx_empty;
    assign err_o     = err_q;
    assign tx_end    = tick && tx_ph_q == 4'(UART_OVERSAMPLE - 1);
    assign tx_o      = (tx_st_q == TX_START) ? 1'b0 :
                       (tx_st_q == TX_DATA) ? tx_sh_q[0] :
                       (tx_st_q == TX_PARITY) ? tx_par_q : 1'b1;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_ph_d   = tick ? tx_ph_q + 1'b1 : tx_ph_q;
        tx_bit_d  = tx_bit_q;
        tx_stop_d = tx_stop_q;
        tx_sh_d   = tx_sh_q;
        tx_par_d  = tx_par_q;
        tx_load   = 1'b0;
        tx_pop    = 1'b0;
        case (tx_st_q)
            TX_IDLE:   tx_load = tick && !tx_empty;
            TX_START:  if (tx_end) begin tx_st_d = TX_DATA; tx_bit_d = '0; end
            TX_DATA: if (tx_end) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 1'b1;
                if (tx_bit_q == 4'(DATA_W - 1)) begin
                    tx_st_d   = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                    tx_stop_d = 1'b0;
                end
            end
            TX_PARITY: if (tx_end) begin tx_st_d = TX_STOP; tx_stop_d = 1'b0; end
            // Reloading straight out of the last stop bit keeps back-to-back words gap-free.
            TX_STOP: if (tx_end) begin
                if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                    tx_st_d = TX_IDLE;
                    tx_load = !tx_empty;
                end else begin
                    tx_stop_d = 1'b1;
                end
            end
            default:   tx_st_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_pop   = 1'b1;
            tx_sh_d  = tx_head;
            tx_par_d = parity_bit(9'(tx_head), PARITY);
            tx_ph_d  = '0;
            tx_st_d  = TX_START;
        end
    end

    assign samp = tick && rx_ph_q == 4'(UART_OVERSAMPLE / 2 - 1);

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_ph_d  = tick ? rx_ph_q + 1'b1 : rx_ph_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        set_par  = 1'b0;
        set_frm  = 1'b0;
        case (rx_st_q)
            RX_IDLE:   if (!rx_s2_q) begin rx_st_d = RX_START; rx_ph_d = '0; end
            RX_START:  if (samp) begin rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA; rx_bit_d = '0; end
            RX_DATA: if (samp) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 4'(DATA_W - 1)) rx_st_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
            end
            RX_PARITY: if (samp) begin
                set_par = rx_s2_q != parity_bit(9'(rx_sh_q), PARITY);
                rx_st_d = RX_STOP;
            end
            RX_STOP: if (samp) begin rx_push = 1'b1; set_frm = !rx_s2_q; rx_st_d = RX_IDLE; end
            default:   rx_st_d = RX_IDLE;
        endcase
    end

    assign err_d = (clr_err_i ? 3'b000 : err_q) | {rx_push && rx_full && !re_i, set_frm, set_par};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q     <= '0;
            tx_st_q   <= TX_IDLE;
            tx_ph_q   <= '0;
            tx_bit_q  <= '0;
            tx_stop_q <= 1'b0;
            tx_sh_q   <= '0;
            tx_par_q  <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_ph_q   <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            err_q     <= '0;
        end else begin
            div_q     <= tick ? '0 : div_q + 1'b1;
            tx_st_q   <= tx_st_d;
            tx_ph_q   <= tx_ph_d;
            tx_bit_q  <= tx_bit_d;
            tx_stop_q <= tx_stop_d;
            tx_sh_q   <= tx_sh_d;
            tx_par_q  <= tx_par_d;
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_st_q   <= rx_st_d;
            rx_ph_q   <= rx_ph_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            err_q     <= err_d;
        end
    end

endmodule
